// File: rtl/team_06_ctrl_pkg.sv
// rtl/team_06_ctrl_pkg.sv - shared state encoding and effect codes for the team_06 voice controller
package team_06_ctrl_pkg;

    typedef enum logic [1:0] {
        LIST = 2'd0,
        TALK = 2'd1,
        HANG = 2'd2
    } ctrl_state_t;

    localparam int unsigned NORMAL  = 0;
    localparam int unsigned ECHO    = 1;
    localparam int unsigned TREMOLO = 2;
    localparam int unsigned REVERB  = 3;
    localparam int unsigned SOFT    = 4;

endpackage

// File: rtl/team_06_btn_debounce.sv
// rtl/team_06_btn_debounce.sv - two-flop synchroniser, stability debouncer and rising-edge pulse for one button
// Ports: clk, rst (sync, active-high), btn_in (raw async button),
//        level (debounced level), rise_pulse (one cycle on accepted 0->1)
module team_06_btn_debounce
    import team_06_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;
    logic          lvl;
    logic          lvl_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            lvl    <= 1'b0;
            lvl_d  <= 1'b0;
        end else begin
            sync_1 <= btn_in;
            sync_2 <= sync_1;
            lvl_d  <= lvl;
            // Any cycle agreeing with the accepted level restarts the stability count.
            if (sync_2 == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                lvl <= sync_2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level      = lvl;
    assign rise_pulse = lvl & ~lvl_d;

endmodule

// File: rtl/team_06_voice_ctrl.sv
// rtl/team_06_voice_ctrl.sv - talk/listen control FSM with noise-gate hang and deferred effect changes
// Ports: clk, rst (sync, active-high); mic_aud/spk_aud samples (offset-binary);
//        ptt_btn, ng_btn, effect_btn, mute_btn raw buttons;
//        state, talk_en, vol_en, current_effect, mute_tog, noise_gate_tog, gate_open
module team_06_voice_ctrl
    import team_06_ctrl_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int NUM_EFFECTS     = 5,
    parameter int GATE_THRESH     = 64,
    parameter int HANG_CYCLES     = 1024,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_W-1:0]              mic_aud,
    input  logic [DATA_W-1:0]              spk_aud,
    input  logic                           ptt_btn,
    input  logic                           ng_btn,
    input  logic                           effect_btn,
    input  logic                           mute_btn,
    output logic [1:0]                     state,
    output logic                           talk_en,
    output logic                           vol_en,
    output logic [$clog2(NUM_EFFECTS)-1:0] current_effect,
    output logic                           mute_tog,
    output logic                           noise_gate_tog,
    output logic                           gate_open
);

    localparam int EW = $clog2(NUM_EFFECTS);
    localparam int HW = (HANG_CYCLES > 1) ? $clog2(HANG_CYCLES) : 1;
    localparam logic [DATA_W-1:0] MID       = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [EW-1:0]     EFF_LAST  = EW'(NUM_EFFECTS - 1);
    localparam logic [HW-1:0]     HANG_INIT = HW'(HANG_CYCLES - 1);
    localparam logic [DATA_W:0]   THRESH    = (DATA_W+1)'(GATE_THRESH);

    function automatic logic [EW-1:0] eff_next(input logic [EW-1:0] e);
        return (e == EFF_LAST) ? '0 : e + 1'b1;
    endfunction

    logic ptt_lvl, unused_ptt_pulse;
    logic unused_ng_lvl, ng_pulse;
    logic unused_eff_lvl, eff_pulse;
    logic unused_mute_lvl, mute_pulse;

    team_06_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ptt (
        .clk(clk), .rst(rst), .btn_in(ptt_btn), .level(ptt_lvl), .rise_pulse(unused_ptt_pulse));
    team_06_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ng (
        .clk(clk), .rst(rst), .btn_in(ng_btn), .level(unused_ng_lvl), .rise_pulse(ng_pulse));
    team_06_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_eff (
        .clk(clk), .rst(rst), .btn_in(effect_btn), .level(unused_eff_lvl), .rise_pulse(eff_pulse));
    team_06_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mute (
        .clk(clk), .rst(rst), .btn_in(mute_btn), .level(unused_mute_lvl), .rise_pulse(mute_pulse));

    // Magnitude about the offset-binary midpoint; the larger operand is always
    // subtracted from, so the result fits DATA_W bits even for mic_aud == 0.
    logic [DATA_W-1:0] mag;
    always_comb begin
        mag = (mic_aud >= MID) ? (mic_aud - MID) : (MID - mic_aud);
    end
    assign gate_open = ({1'b0, mag} >= THRESH);

    ctrl_state_t   state_q, state_d;
    logic [HW-1:0] hang_cnt, hang_d;
    logic          pend;
    logic          spk, req;

    assign spk = (spk_aud != '0);
    assign req = ptt_lvl | (noise_gate_tog & gate_open);

    always_comb begin
        state_d = state_q;
        hang_d  = hang_cnt;
        case (state_q)
            LIST: begin
                if (!spk && req) state_d = TALK;
            end
            TALK: begin
                if (spk)                              state_d = LIST;
                else if (ptt_lvl)                     state_d = TALK;
                else if (noise_gate_tog && gate_open) state_d = TALK;
                else if (noise_gate_tog) begin
                    state_d = HANG;
                    hang_d  = HANG_INIT;
                end
                else                                  state_d = LIST;
            end
            HANG: begin
                if (spk || !noise_gate_tog) state_d = LIST;
                else if (req)               state_d = TALK;
                else if (hang_cnt == '0)    state_d = LIST;
                else                        hang_d  = hang_cnt - 1'b1;
            end
            default: state_d = LIST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= LIST;
            hang_cnt       <= '0;
            pend           <= 1'b0;
            current_effect <= EW'(NORMAL);
            mute_tog       <= 1'b0;
            noise_gate_tog <= 1'b0;
        end else begin
            state_q  <= state_d;
            hang_cnt <= hang_d;
            if (mute_pulse) mute_tog       <= ~mute_tog;
            if (ng_pulse)   noise_gate_tog <= ~noise_gate_tog;
            // Effect changes are held while transmitting so the far end never
            // hears a switch mid-phrase; they land on the first listen cycle.
            if (state_q == LIST) begin
                if (pend && eff_pulse)     current_effect <= eff_next(eff_next(current_effect));
                else if (pend || eff_pulse) current_effect <= eff_next(current_effect);
                pend <= 1'b0;
            end else if (eff_pulse) begin
                pend <= 1'b1;
            end
        end
    end

    assign state   = state_q;
    assign talk_en = (state_q != LIST);
    assign vol_en  = (state_q == LIST) & ~mute_tog;

endmodule
